// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes, ALU ops and mux selects.
// Pure definitions, no logic.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_JUMP   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

endpackage

// File: rtl/mcu_opclass.sv
// Combinational opcode -> instruction class decode plus the EXEC-phase ALU op.
// Zero latency; no handshake.
module mcu_opclass #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_rtype,
  output logic                o_imm,
  output logic                o_load,
  output logic                o_store,
  output logic                o_branch,
  output logic                o_bne,
  output logic                o_jump,
  output logic                o_link,
  output logic                o_byte,
  output logic                o_move,
  output logic                o_illegal,
  output logic [ALUOP_W-1:0]  o_alu_op
);
  import mcu_pkg::*;

  always_comb begin
    o_rtype   = 1'b0;
    o_imm     = 1'b0;
    o_load    = 1'b0;
    o_store   = 1'b0;
    o_branch  = 1'b0;
    o_bne     = 1'b0;
    o_jump    = 1'b0;
    o_link    = 1'b0;
    o_byte    = 1'b0;
    o_move    = 1'b0;
    o_illegal = 1'b0;
    o_alu_op  = '0;
    case (i_opcode)
      OPCODE_W'(OP_RTYPE): begin o_rtype = 1'b1; o_alu_op = ALUOP_W'(ALU_FUNCT); end
      OPCODE_W'(OP_ADDI):  begin o_imm = 1'b1;   o_alu_op = ALUOP_W'(ALU_ADD); end
      OPCODE_W'(OP_SUBI):  begin o_imm = 1'b1;   o_alu_op = ALUOP_W'(ALU_SUB); end
      OPCODE_W'(OP_ANDI):  begin o_imm = 1'b1;   o_alu_op = ALUOP_W'(ALU_AND); end
      OPCODE_W'(OP_ORI):   begin o_imm = 1'b1;   o_alu_op = ALUOP_W'(ALU_OR); end
      OPCODE_W'(OP_SLTI):  begin o_imm = 1'b1;   o_alu_op = ALUOP_W'(ALU_SLT); end
      OPCODE_W'(OP_LW):    begin o_load = 1'b1;  o_alu_op = ALUOP_W'(ALU_ADD); end
      OPCODE_W'(OP_LB):    begin o_load = 1'b1;  o_byte = 1'b1; o_alu_op = ALUOP_W'(ALU_ADD); end
      OPCODE_W'(OP_SW):    begin o_store = 1'b1; o_alu_op = ALUOP_W'(ALU_ADD); end
      OPCODE_W'(OP_SB):    begin o_store = 1'b1; o_byte = 1'b1; o_alu_op = ALUOP_W'(ALU_ADD); end
      OPCODE_W'(OP_MOVE):  begin o_move = 1'b1;  o_alu_op = ALUOP_W'(ALU_SLT); end
      OPCODE_W'(OP_BEQ):   begin o_branch = 1'b1; o_alu_op = ALUOP_W'(ALU_SUB); end
      OPCODE_W'(OP_BNE):   begin o_branch = 1'b1; o_bne = 1'b1; o_alu_op = ALUOP_W'(ALU_SUB); end
      OPCODE_W'(OP_J):     begin o_jump = 1'b1;  o_alu_op = ALUOP_W'(ALU_SLT); end
      OPCODE_W'(OP_JAL):   begin o_jump = 1'b1;  o_link = 1'b1; o_alu_op = ALUOP_W'(ALU_SLT); end
      default:             o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit: fetch/decode/exec/mem/wb sequencing, 3-5 cycles per instruction plus
// one per memory wait cycle; stalls on i_mem_ready and faults if a wait reaches MEM_TIMEOUT cycles.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_i_or_d,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic [1:0]          o_pc_src,
  output logic                o_reg_dst,
  output logic                o_reg_write,
  output logic                o_link,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_byte_operations,
  output logic                o_move,
  output logic                o_jump,
  output logic                o_instr_done,
  output logic                o_fault,
  output logic [2:0]          o_state
);
  import mcu_pkg::*;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_wait_inc;
  logic               w_waiting;
  logic               w_timeout;

  logic w_rtype, w_imm, w_load, w_store, w_branch, w_bne;
  logic w_jump, w_link, w_byte, w_move, w_illegal;
  logic [ALUOP_W-1:0] w_alu_op;

  mcu_opclass #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_opclass (
    .i_opcode  (i_opcode),
    .o_rtype   (w_rtype),
    .o_imm     (w_imm),
    .o_load    (w_load),
    .o_store   (w_store),
    .o_branch  (w_branch),
    .o_bne     (w_bne),
    .o_jump    (w_jump),
    .o_link    (w_link),
    .o_byte    (w_byte),
    .o_move    (w_move),
    .o_illegal (w_illegal),
    .o_alu_op  (w_alu_op)
  );

  // The fault fires on the wait cycle that would bring the count to the limit; a ready in that
  // same cycle is not a wait cycle, so the access completes instead.
  assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !i_mem_ready;
  assign w_wait_inc = r_wait_cnt + 1'b1;
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_waiting && (w_wait_inc == CNT_W'(MEM_TIMEOUT));
  assign o_state    = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state)
        r_wait_cnt <= '0;
      else if (w_waiting && (MEM_TIMEOUT != 0))
        r_wait_cnt <= w_wait_inc;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_i_or_d          = 1'b0;
    o_ir_write        = 1'b0;
    o_pc_write        = 1'b0;
    o_pc_src          = PCSRC_ALU;
    o_reg_dst         = 1'b0;
    o_reg_write       = 1'b0;
    o_link            = 1'b0;
    o_alu_src_a       = 1'b0;
    o_alu_src_b       = SRCB_REG;
    o_alu_op          = '0;
    o_byte_operations = 1'b0;
    o_move            = 1'b0;
    o_jump            = 1'b0;
    o_instr_done      = 1'b0;
    o_fault           = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_mem_read = 1'b1;
        if (i_mem_ready) begin
          o_ir_write   = 1'b1;
          o_pc_write   = 1'b1;
          o_alu_src_b  = SRCB_FOUR;
          w_state_next = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        o_alu_src_b = SRCB_BRANCH;
        if (w_illegal)     w_state_next = ST_FAULT;
        else if (w_branch) w_state_next = ST_BRANCH;
        else if (w_jump)   w_state_next = ST_JUMP;
        else               w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        o_alu_src_a       = 1'b1;
        o_alu_src_b       = w_rtype ? SRCB_REG : SRCB_IMM;
        o_alu_op          = w_alu_op;
        o_byte_operations = w_byte;
        w_state_next      = (w_rtype || w_imm || w_move) ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        o_i_or_d          = 1'b1;
        o_mem_read        = w_load;
        o_mem_write       = w_store;
        o_byte_operations = w_byte;
        if (i_mem_ready) begin
          o_instr_done = w_store;
          w_state_next = w_store ? ST_FETCH : ST_WB;
        end else if (w_timeout) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_WB: begin
        o_reg_write       = 1'b1;
        o_reg_dst         = w_rtype;
        o_move            = w_move;
        o_byte_operations = w_byte;
        o_instr_done      = 1'b1;
        w_state_next      = ST_FETCH;
      end
      ST_BRANCH: begin
        o_alu_op     = ALUOP_W'(ALU_SUB);
        o_pc_src     = PCSRC_ALUOUT;
        o_pc_write   = w_bne ? !i_zero : i_zero;
        o_instr_done = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_JUMP: begin
        o_pc_write   = 1'b1;
        o_pc_src     = PCSRC_JUMP;
        o_jump       = 1'b1;
        o_reg_write  = w_link;
        o_link       = w_link;
        o_instr_done = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_FAULT: o_fault = 1'b1;
      default:  w_state_next = ST_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction stream scored per instruction against a behavioural model, plus directed
// fault, timeout and reset-abort scenarios.
module tb_multicycle_control_unit;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [5:0] i_opcode = '0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       o_mem_read, o_mem_write, o_i_or_d, o_ir_write, o_pc_write;
  logic [1:0] o_pc_src;
  logic       o_reg_dst, o_reg_write, o_link, o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [2:0] o_alu_op;
  logic       o_byte_operations, o_move, o_jump, o_instr_done, o_fault;
  logic [2:0] o_state;

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_i_or_d(o_i_or_d), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
    .o_pc_src(o_pc_src), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
    .o_link(o_link), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_byte_operations(o_byte_operations), .o_move(o_move),
    .o_jump(o_jump), .o_instr_done(o_instr_done), .o_fault(o_fault), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Per-instruction summary; path holds visited states as digits (state number + 1).
  typedef struct {
    logic [5:0] op;
    int lat, path, alu, n_rw, n_pcw, n_mrd, n_mwr, n_byte, n_irw, rdst, mv, lnk, jmp;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [5:0] ops [15] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                           6'b000111, 6'b001000, 6'b001001, 6'b010000, 6'b010001,
                           6'b100000, 6'b100011, 6'b100111, 6'b111000, 6'b111001};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input int fw, input int mw, input logic z);
    exp_t r;
    bit is_load = 0, is_store = 0, is_br = 0, is_jmp = 0, is_byte = 0, taken = 0;
    r.op = op; r.alu = -1; r.rdst = 0; r.mv = 0; r.lnk = 0;
    case (op)
      6'b000000: begin r.alu = 7; r.rdst = 1; end
      6'b000010: r.alu = 5;
      6'b000011: r.alu = 6;
      6'b000100: r.alu = 0;
      6'b000101: r.alu = 1;
      6'b000111: r.alu = 4;
      6'b100000: begin r.alu = 4; r.mv = 1; end
      6'b001000: begin r.alu = 5; is_load = 1; end
      6'b001001: begin r.alu = 5; is_load = 1; is_byte = 1; end
      6'b010000: begin r.alu = 5; is_store = 1; end
      6'b010001: begin r.alu = 5; is_store = 1; is_byte = 1; end
      6'b100011: begin r.alu = 6; is_br = 1; taken = z; end
      6'b100111: begin r.alu = 6; is_br = 1; taken = !z; end
      6'b111000: is_jmp = 1;
      6'b111001: begin is_jmp = 1; r.lnk = 1; end
      default: ;
    endcase
    r.jmp = int'(is_jmp);
    if (is_br)         begin r.path = 126;   r.lat = fw + 3; end
    else if (is_jmp)   begin r.path = 127;   r.lat = fw + 3; end
    else if (is_load)  begin r.path = 12345; r.lat = fw + mw + 5; end
    else if (is_store) begin r.path = 1234;  r.lat = fw + mw + 4; end
    else               begin r.path = 1235;  r.lat = fw + 4; end
    r.n_rw   = (is_br || is_store || (is_jmp && r.lnk == 0)) ? 0 : 1;
    r.n_pcw  = 1 + int'(taken) + int'(is_jmp);
    r.n_mrd  = fw + 1 + (is_load ? mw + 1 : 0);
    r.n_mwr  = is_store ? mw + 1 : 0;
    r.n_byte = !is_byte ? 0 : (is_load ? mw + 3 : mw + 2);
    r.n_irw  = 1;
    return r;
  endfunction

  // Monitor: accumulates one instruction's observed behaviour and scores it on instr_done.
  int m_cyc = 0, m_path = 0, m_last = -1, m_alu = -1, m_rw = 0, m_pcw = 0, m_mrd = 0;
  int m_mwr = 0, m_byte = 0, m_irw = 0, m_rdst = 0, m_mv = 0, m_lnk = 0, m_jmp = 0;

  always @(negedge i_clk) begin
    if (mon_en && i_rst_n) begin
      m_cyc++;
      if (int'(o_state) != m_last) begin
        m_path = m_path * 10 + int'(o_state) + 1;
        m_last = int'(o_state);
      end
      if (o_state == 3'd2 || o_state == 3'd5) m_alu = int'(o_alu_op);
      m_rw   += int'(o_reg_write);
      m_pcw  += int'(o_pc_write);
      m_mrd  += int'(o_mem_read);
      m_mwr  += int'(o_mem_write);
      m_byte += int'(o_byte_operations);
      m_irw  += int'(o_ir_write);
      m_rdst |= int'(o_reg_dst);
      m_mv   |= int'(o_move);
      m_lnk  |= int'(o_link);
      m_jmp  |= int'(o_jump);
      if (o_instr_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_instr_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("op%b latency", e.op), m_cyc, e.lat);
          chk($sformatf("op%b state_path", e.op), m_path, e.path);
          chk($sformatf("op%b alu_op", e.op), m_alu, e.alu);
          chk($sformatf("op%b reg_write_cycles", e.op), m_rw, e.n_rw);
          chk($sformatf("op%b pc_write_cycles", e.op), m_pcw, e.n_pcw);
          chk($sformatf("op%b mem_read_cycles", e.op), m_mrd, e.n_mrd);
          chk($sformatf("op%b mem_write_cycles", e.op), m_mwr, e.n_mwr);
          chk($sformatf("op%b byte_cycles", e.op), m_byte, e.n_byte);
          chk($sformatf("op%b ir_write_cycles", e.op), m_irw, e.n_irw);
          chk($sformatf("op%b reg_dst", e.op), m_rdst, e.rdst);
          chk($sformatf("op%b move", e.op), m_mv, e.mv);
          chk($sformatf("op%b link", e.op), m_lnk, e.lnk);
          chk($sformatf("op%b jump", e.op), m_jmp, e.jmp);
        end
        m_cyc = 0; m_path = 0; m_last = -1; m_alu = -1; m_rw = 0; m_pcw = 0; m_mrd = 0;
        m_mwr = 0; m_byte = 0; m_irw = 0; m_rdst = 0; m_mv = 0; m_lnk = 0; m_jmp = 0;
      end
    end
  end

  // Called at posedge+1 in the instruction's first FETCH cycle; returns at posedge+1 of the next.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    int fc = 0, mc = 0, guard = 0;
    bit done = 0;
    sb_q.push_back(model(op, fw, mw, z));
    i_opcode = op;
    i_zero   = z;
    while (!done && guard < 60) begin
      case (o_state)
        3'd0:    begin i_mem_ready = (fc == fw); fc++; end
        3'd3:    begin i_mem_ready = (mc == mw); mc++; end
        default: i_mem_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      done = o_instr_done;
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (!done) chk($sformatf("op%b completion_within_budget", op), 0, 1);
  endtask

  function automatic int enables();
    logic [19:0] v;
    v = {o_mem_read, o_mem_write, o_i_or_d, o_ir_write, o_pc_write, o_pc_src, o_reg_dst,
         o_reg_write, o_link, o_alu_src_a, o_alu_src_b, o_alu_op, o_byte_operations,
         o_move, o_jump, o_instr_done};
    return int'(v);
  endfunction

  task automatic reset_and_release(input logic [5:0] op, input logic rdy);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_opcode    = op;
    i_mem_ready = rdy;
    i_rst_n     = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_state", int'(o_state), 0);
    chk("reset_fault", int'(o_fault), 0);
    chk("reset_instr_done", int'(o_instr_done), 0);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    run_instr(6'b000010, 0, 0, 1'b0);  // addi, zero-wait
    run_instr(6'b001000, 0, 2, 1'b0);  // lw, two MEM waits
    run_instr(6'b100011, 0, 0, 1'b1);  // beq taken
    run_instr(6'b100111, 0, 0, 1'b1);  // bne not taken
    run_instr(6'b111001, 0, 0, 1'b0);  // jal
    for (int k = 0; k < 80; k++)
      run_instr(ops[$urandom_range(0, 14)], $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    chk("scoreboard_drained", sb_q.size(), 0);
    mon_en = 1'b0;

    // Illegal opcode: FAULT on cycle 3, absorbing, cleared only by reset.
    reset_and_release(6'b110000, 1'b1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("illegal_state_cycle3", int'(o_state), 7);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("fault_sticky_c%0d", c), int'(o_fault), 1);
      chk($sformatf("fault_enables_c%0d", c), enables(), 0);
      i_mem_ready = 1'($urandom_range(0, 1));
      i_opcode    = 6'($urandom_range(0, 63));
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    #1;
    chk("fault_reset_state", int'(o_state), 0);
    chk("fault_reset_fault", int'(o_fault), 0);

    // Fetch never answered: 15 wait cycles, then FAULT.
    reset_and_release(6'b000010, 1'b0);
    n = 0;
    while (o_state == 3'd0 && n < 40) begin
      n++;
      @(posedge i_clk); #1;
    end
    chk("timeout_fetch_cycles", n, 15);
    chk("timeout_state", int'(o_state), 7);
    chk("timeout_fault", int'(o_fault), 1);

    // Ready arriving on the 15th fetch cycle beats the timeout.
    reset_and_release(6'b000010, 1'b0);
    repeat (14) begin
      @(posedge i_clk); #1;
    end
    chk("late_ready_still_fetch", int'(o_state), 0);
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("late_ready_state", int'(o_state), 1);
    chk("late_ready_fault", int'(o_fault), 0);

    // Reset during a stalled store's MEM phase drops the write at once.
    reset_and_release(6'b010000, 1'b1);
    n = 0;
    while (o_state != 3'd3 && n < 20) begin
      i_mem_ready = (o_state == 3'd0);
      n++;
      @(posedge i_clk); #1;
    end
    i_mem_ready = 1'b0;
    #1;
    chk("abort_reached_mem", int'(o_state), 3);
    chk("abort_write_active", int'(o_mem_write), 1);
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    chk("abort_state", int'(o_state), 0);
    chk("abort_mem_write", int'(o_mem_write), 0);
    chk("abort_instr_done", int'(o_instr_done), 0);
    chk("abort_pc_write", int'(o_pc_write), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
